// File: rtl/port_rx_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : port_rx_buffer
//  Purpose  : Receive-side frame reassembly and show-ahead FIFO for one
//             egress port of the 4-port switch. Beats from the output mux
//             are staged for one cycle, so that the last beat of each frame
//             can be tagged before it is written. Because the link has no
//             backpressure, overflow is resolved with counted drops.
//  Options  : PORT_RX_STATS_EN - when defined, frame_cnt and drop_cnt are
//             implemented. Otherwise both outputs are tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module port_rx_buffer #(
   parameter int FIFO_DEPTH = 8,
   // Half of the switch's 16-bit packet data width.
   parameter int BEAT_W     = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          valid_in,
   input  logic [BEAT_W-1:0]             data_in,
   input  logic                          rd_en,
   output logic                          rd_valid,
   output logic [BEAT_W-1:0]             rd_data,
   output logic                          rd_last,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic [15:0]                   frame_cnt,
   output logic [15:0]                   drop_cnt
);

   localparam int                AW           = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]       c_FULL_LEVEL = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,   // nothing staged
      ST_HOLD  = 2'd1,   // staged beat, frame still open
      ST_FLUSH = 2'd2    // frame closed, staged last beat waiting for space
   } state_t;

   state_t            state_q;
   logic [BEAT_W-1:0] stg_data_q;
   logic [AW:0]       wr_ptr_q;
   logic [AW:0]       rd_ptr_q;
   logic [BEAT_W:0]   mem_q [FIFO_DEPTH];   // {last, data}

   logic              w_pop;
   logic              w_push_ok;
   logic              w_push;
   logic              w_push_last;
   logic [BEAT_W:0]   w_head;

   // Occupancy flags come straight from the registered pointers.
   assign level    = wr_ptr_q - rd_ptr_q;
   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (level == c_FULL_LEVEL);
   assign rd_valid = !empty;

   // A pop on the same edge frees the slot a push needs, even when full.
   assign w_pop     = rd_en && !empty;
   assign w_push_ok = !full || w_pop;

   // Show-ahead head; forced to zero while empty so stale entries never leak.
   assign w_head  = mem_q[rd_ptr_q[AW-1:0]];
   assign rd_data = empty ? '0 : w_head[BEAT_W-1:0];
   assign rd_last = !empty && w_head[BEAT_W];

   // Decide whether the staged beat is written this cycle and with which tag.
   always_comb begin
      w_push      = 1'b0;
      w_push_last = 1'b0;
      case (state_q)
         ST_HOLD: begin
            if (w_push_ok) begin
               w_push      = 1'b1;
               w_push_last = !valid_in;
            end
         end
         ST_FLUSH: begin
            if (w_push_ok) begin
               w_push      = 1'b1;
               w_push_last = 1'b1;
            end
         end
         default: begin
            w_push      = 1'b0;
            w_push_last = 1'b0;
         end
      endcase
   end

   // Frame tracking state machine with its one-entry staging register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         stg_data_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (valid_in) begin
                  stg_data_q <= data_in;
                  state_q    <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (valid_in) begin
                  // Without space the incoming beat is dropped and the
                  // staged beat is kept.
                  if (w_push_ok) begin
                     stg_data_q <= data_in;
                  end
               end else begin
                  state_q <= w_push_ok ? ST_IDLE : ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               if (w_push_ok) begin
                  if (valid_in) begin
                     // A new frame starts here; its earlier beats were
                     // dropped while the FIFO was full.
                     stg_data_q <= data_in;
                     state_q    <= ST_HOLD;
                  end else begin
                     state_q    <= ST_IDLE;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // FIFO pointers; the extra MSB separates full from empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (w_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (w_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

   // Storage array write; the contents need no reset because the output is
   // masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (w_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= {w_push_last, stg_data_q};
      end
   end

`ifdef PORT_RX_STATS_EN
   logic [15:0] frame_cnt_q;
   logic [15:0] drop_cnt_q;
   logic        w_drop;
   logic        w_frame_done;

   // Any beat that arrives while a staged beat is still waiting for space is
   // lost, whether the frame is open or already closed.
   assign w_drop       = (state_q != ST_IDLE) && valid_in && !w_push_ok;
   assign w_frame_done = w_push && w_push_last;

   // Saturating frame and drop statistics.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_cnt_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         if (w_frame_done && (frame_cnt_q != 16'hFFFF)) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
         end
         if (w_drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
         end
      end
   end

   assign frame_cnt = frame_cnt_q;
   assign drop_cnt  = drop_cnt_q;
`else
   assign frame_cnt = 16'h0000;
   assign drop_cnt  = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_port_rx_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_port_rx_buffer
//  Purpose  : Directed self-checking bench for port_rx_buffer. A queue-based
//             model of frames, staging and drops is compared against the DUT
//             on every falling edge; literal checks pin the key scenarios.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_port_rx_buffer;

   localparam int DEPTH = 8;
   localparam int BW    = 8;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          valid_in;
   logic [BW-1:0] data_in;
   logic          rd_en;
   logic          rd_valid;
   logic [BW-1:0] rd_data;
   logic          rd_last;
   logic          full;
   logic          empty;
   logic [LW-1:0] level;
   logic [15:0]   frame_cnt;
   logic [15:0]   drop_cnt;

   port_rx_buffer #(
      .FIFO_DEPTH (DEPTH),
      .BEAT_W     (BW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .valid_in  (valid_in),
      .data_in   (data_in),
      .rd_en     (rd_en),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data),
      .rd_last   (rd_last),
      .full      (full),
      .empty     (empty),
      .level     (level),
      .frame_cnt (frame_cnt),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Model state: FIFO contents as {last,data}, plus one pending beat.
   logic [BW:0] m_q [$];
   bit          m_pend   = 1'b0;
   bit          m_closed = 1'b0;
   logic [BW-1:0] m_pd   = '0;
   int          m_frames = 0;
   int          m_drops  = 0;
   bit          chk_en   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Statistics outputs only carry counts when the option is compiled in.
   function automatic logic [31:0] stats(input int v);
`ifdef PORT_RX_STATS_EN
      return (v > 65535) ? 32'd65535 : 32'(v);
`else
      return (v >= 0) ? 32'd0 : 32'd0;
`endif
   endfunction

   // One clock edge of frame/FIFO behaviour, written from the frame rules.
   task automatic model_update(input bit v, input logic [BW-1:0] d, input bit r);
      bit pop;
      bit space;
      bit last;
      pop   = r && (m_q.size() > 0);
      space = (m_q.size() < DEPTH) || pop;
      if (pop) void'(m_q.pop_front());
      if (m_pend) begin
         last = m_closed || !v;
         if (space) begin
            m_q.push_back({last, m_pd});
            if (last) m_frames++;
            m_pend = 1'b0;
         end else if (v) begin
            m_drops++;
         end else begin
            m_closed = 1'b1;
         end
      end
      if (v && !m_pend) begin
         m_pend   = 1'b1;
         m_pd     = d;
         m_closed = 1'b0;
      end
   endtask

   task automatic model_clear();
      m_q.delete();
      m_pend   = 1'b0;
      m_closed = 1'b0;
      m_frames = 0;
      m_drops  = 0;
   endtask

   // Continuous comparison of every output against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("rd_valid",  rd_valid,  (m_q.size() > 0) ? 1 : 0);
         check("rd_data",   rd_data,   (m_q.size() > 0) ? 32'(m_q[0][BW-1:0]) : 0);
         check("rd_last",   rd_last,   (m_q.size() > 0) ? 32'(m_q[0][BW]) : 0);
         check("level",     level,     m_q.size());
         check("full",      full,      (m_q.size() == DEPTH) ? 1 : 0);
         check("empty",     empty,     (m_q.size() == 0) ? 1 : 0);
         check("frame_cnt", frame_cnt, stats(m_frames));
         check("drop_cnt",  drop_cnt,  stats(m_drops));
      end
   end

   // Drive one cycle, let the edge occur, then advance the model.
   task automatic step(input bit v, input logic [BW-1:0] d, input bit r);
      valid_in = v;
      data_in  = d;
      rd_en    = r;
      @(posedge clk);
      #1;
      model_update(v, d, r);
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      valid_in = 1'b0;
      data_in  = '0;
      rd_en    = 1'b0;
      model_clear();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   initial begin
      rst      = 1'b1;
      valid_in = 1'b0;
      data_in  = '0;
      rd_en    = 1'b0;
      chk_en   = 1'b1;

      // Reset values
      do_reset();
      check("rst rd_valid",  rd_valid,  0);
      check("rst rd_data",   rd_data,   0);
      check("rst rd_last",   rd_last,   0);
      check("rst full",      full,      0);
      check("rst empty",     empty,     1);
      check("rst level",     level,     0);
      check("rst frame_cnt", frame_cnt, 0);
      check("rst drop_cnt",  drop_cnt,  0);

      // Three-beat frame, 2-cycle latency, then drain
      step(1'b1, 8'hA1, 1'b0);
      check("f3 rd_valid c1", rd_valid, 0);
      step(1'b1, 8'hA2, 1'b0);
      check("f3 rd_valid c2", rd_valid, 1);
      check("f3 level c2",    level,    1);
      step(1'b1, 8'hA3, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      check("f3 level",     level,     3);
      check("f3 frame_cnt", frame_cnt, stats(1));
      check("f3 head0",     {rd_last, rd_data}, {1'b0, 8'hA1});
      step(1'b0, 8'h00, 1'b1);
      check("f3 head1",     {rd_last, rd_data}, {1'b0, 8'hA2});
      step(1'b0, 8'h00, 1'b1);
      check("f3 head2",     {rd_last, rd_data}, {1'b1, 8'hA3});
      step(1'b0, 8'h00, 1'b1);
      check("f3 empty",     empty, 1);

      // Single-beat frame
      do_reset();
      step(1'b1, 8'h55, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      check("f1 level c2", level, 1);
      check("f1 head",     {rd_last, rd_data}, {1'b1, 8'h55});

      // 12-beat frame into an 8-deep FIFO: overflow, FLUSH, release
      do_reset();
      for (int i = 0; i < 12; i++) step(1'b1, BW'(8'h10 + i), 1'b0);
      step(1'b0, 8'h00, 1'b0);
      check("ovf level",     level,     8);
      check("ovf full",      full,      1);
      check("ovf drop_cnt",  drop_cnt,  stats(3));
      check("ovf frame_cnt", frame_cnt, stats(0));
      check("ovf head",      {rd_last, rd_data}, {1'b0, 8'h10});
      step(1'b0, 8'h00, 1'b1);
      check("ovf frame_cnt rel", frame_cnt, stats(1));
      check("ovf level rel",     level,     8);
      for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1);
      check("ovf tail", {rd_last, rd_data}, {1'b1, 8'h18});

      // Full FIFO, simultaneous push and pop every cycle
      do_reset();
      for (int i = 0; i < 9; i++) step(1'b1, BW'(8'h20 + i), 1'b0);
      check("pp full", full, 1);
      for (int i = 0; i < 10; i++) step(1'b1, BW'(8'h40 + i), 1'b1);
      check("pp level", level,    8);
      check("pp drop",  drop_cnt, stats(0));
      step(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);
      check("pp empty", empty, 1);

      // FLUSH released while a new frame starts
      do_reset();
      for (int i = 0; i < 10; i++) step(1'b1, BW'(8'h60 + i), 1'b0);
      step(1'b0, 8'h00, 1'b0);
      step(1'b1, 8'hE0, 1'b1);
      step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b1);
      check("fr frame_cnt", frame_cnt, stats(2));
      check("fr drop_cnt",  drop_cnt,  stats(1));
      check("fr level",     level,     8);
      for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);

      // Reset mid-frame after two beats
      do_reset();
      step(1'b1, 8'hC1, 1'b0);
      step(1'b1, 8'hC2, 1'b0);
      rst = 1'b1;
      model_clear();
      #1;
      check("mid empty", empty, 1);
      check("mid level", level, 0);
      valid_in = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      step(1'b1, 8'hD1, 1'b0);
      step(1'b1, 8'hD2, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      check("mid level2", level, 2);
      check("mid head0",  {rd_last, rd_data}, {1'b0, 8'hD1});
      step(1'b0, 8'h00, 1'b1);
      check("mid head1",  {rd_last, rd_data}, {1'b1, 8'hD2});
      step(1'b0, 8'h00, 1'b1);

      @(negedge clk);
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
